// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry elastic pipeline register (main + skid).
//
// A single-cycle-latency pipeline stage with valid/ready handshakes on both
// sides. The skid entry lets in_ready be driven purely from state, so there
// is no combinational path from out_ready to in_ready, while still sustaining
// one entry per cycle when downstream is ready.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   flush      - synchronous kill of all held entries
//   in_valid   - upstream entry valid
//   in_ready   - stage can accept an entry (registered state only)
//   in_ctrl    - control flags (write-enable style)
//   in_data0   - payload A
//   in_data1   - payload B
//   in_tag     - destination tag
//   out_valid  - entry presented downstream
//   out_ready  - downstream accepts
//   out_ctrl   - control flags, forced to zero on bubbles
//   out_data0  - payload A of main entry
//   out_data1  - payload B of main entry
//   out_tag    - destination tag of main entry
//   stall_cnt  - saturating count of back-pressured cycles
//
// Configuration:
//   PIPE_STALL_CNT_EN - when defined, stall_cnt counts cycles with
//   out_valid=1 and out_ready=0 (saturating at 0xFFFF, cleared only by
//   reset). When undefined, stall_cnt is tied to zero and no counter exists.

module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic accept;
  logic release_ent;

  assign in_entry = '{ctrl: in_ctrl, data0: in_data0, data1: in_data1, tag: in_tag};

  // Both handshake flags derive from state only.
  assign in_ready    = (state_q != StFull);
  assign out_valid   = (state_q == StHalf) || (state_q == StFull);
  assign accept      = in_valid & in_ready;
  assign release_ent = out_valid & out_ready;

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = StHalf;
        end
      end
      StHalf: begin
        if (accept && release_ent) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = StFull;
        end else if (release_ent) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so no accept can coincide.
        if (release_ent) begin
          main_d  = skid_q;
          state_d = StHalf;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    // Flush overrides any handshake update; a same-cycle release has already
    // been seen downstream, and a same-cycle offer is simply dropped.
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Bubbles must never assert write controls.
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign out_data0 = main_q.data0;
  assign out_data1 = main_q.data1;
  assign out_tag   = main_q.tag;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        stall_now;

  assign stall_now = out_valid & ~out_ready;

  // Not cleared by flush: this is a performance counter, not pipeline state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_now && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
